// File: rtl/nes_pkg.sv
// rtl/nes_pkg.sv - shared constants and state type for the NES controller responder
package nes_pkg;
   localparam int NES_NUM_BUTTONS = 8;

   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   localparam logic [3:0] NES_LAST_COUNT = 4'd7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } nes_state_t;
endpackage

// File: rtl/nes_input_sync.sv
// rtl/nes_input_sync.sv - synchronizer, optional debounce (NES_RESP_GLITCH_FILTER_EN), edge pulses
module nes_input_sync #(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= '0;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], din};
   end

`ifdef NES_RESP_GLITCH_FILTER_EN
   localparam int CW = $clog2(FILTER_CYCLES + 1);
   logic [CW-1:0] cnt_q;
   logic          filt_q;

   // Level flips only on the FILTER_CYCLES-th consecutive disagreeing sample.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q  <= '0;
         filt_q <= 1'b0;
      end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
         cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
         cnt_q  <= '0;
         filt_q <= sync_q[SYNC_STAGES-1];
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign level = filt_q;
`else
   localparam int unused_filter_cycles = FILTER_CYCLES;
   assign level = sync_q[SYNC_STAGES-1];
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) prev_q <= 1'b0;
      else          prev_q <= level;
   end

   assign rise = level & ~prev_q;
   assign fall = ~level & prev_q;
endmodule

// File: rtl/nes_controller_responder.sv
// rtl/nes_controller_responder.sv - 4021-style NES controller emulation; NES_RESP_GLITCH_FILTER_EN adds input debounce
module nes_controller_responder
   import nes_pkg::*;
#(
   parameter int   SYNC_STAGES   = 2,
   parameter logic FILL_BIT      = 1'b0,
   parameter int   FILTER_CYCLES = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] buttons,
   input  logic       nes_latch,
   input  logic       nes_clock,
   output logic       nes_data,
   output logic       frame_done,
   output logic       busy
);
   logic latch_level, latch_rise, latch_fall;
   logic clock_rise, unused_clock_level, unused_clock_fall;

   nes_input_sync #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_latch_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (nes_latch),
      .level   (latch_level),
      .rise    (latch_rise),
      .fall    (latch_fall)
   );

   nes_input_sync #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_clock_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (nes_clock),
      .level   (unused_clock_level),
      .rise    (clock_rise),
      .fall    (unused_clock_fall)
   );

   nes_state_t                 state_q, state_d;
   logic [NES_NUM_BUTTONS-1:0] shreg_q, shreg_d;
   logic [3:0]                 count_q, count_d;
   logic                       nes_data_d, frame_done_d, busy_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Latch rising takes priority over a coincident clock rising.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (latch_level) state_d = LOAD;
         LOAD:    if (latch_fall)  state_d = SHIFT;
         SHIFT: begin
            if (latch_rise)
               state_d = LOAD;
            else if (clock_rise && count_q == NES_LAST_COUNT)
               state_d = DONE;
         end
         DONE:    if (latch_rise)  state_d = LOAD;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      shreg_d      = shreg_q;
      count_d      = count_q;
      frame_done_d = 1'b0;
      if (state_d == LOAD) begin
         shreg_d = buttons;
         count_d = 4'd0;
      end else if (state_q == SHIFT && clock_rise) begin
         shreg_d      = {1'b0, shreg_q[NES_NUM_BUTTONS-1:1]};
         count_d      = count_q + 4'd1;
         frame_done_d = (count_q == NES_LAST_COUNT);
      end
      busy_d     = (state_d == LOAD) || (state_d == SHIFT);
      nes_data_d = (state_d == DONE) ? FILL_BIT : ~shreg_d[BTN_A];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shreg_q    <= '0;
         count_q    <= 4'd0;
         nes_data   <= 1'b1;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         shreg_q    <= shreg_d;
         count_q    <= count_d;
         nes_data   <= nes_data_d;
         frame_done <= frame_done_d;
         busy       <= busy_d;
      end
   end
endmodule

// File: tb/tb_nes_controller_responder.sv
// tb/tb_nes_controller_responder.sv - directed bench for nes_controller_responder
module tb_nes_controller_responder;
   localparam int PH = 8;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] buttons;
   logic       nes_latch;
   logic       nes_clock;
   logic       nes_data;
   logic       frame_done;
   logic       busy;

   int total = 0;
   int bad   = 0;
   int fd_count = 0;
   int fd0;

   nes_controller_responder dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .buttons    (buttons),
      .nes_latch  (nes_latch),
      .nes_clock  (nes_clock),
      .nes_data   (nes_data),
      .frame_done (frame_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (frame_done === 1'b1) fd_count++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic host_latch();
      nes_latch = 1'b1;
      cycles(PH);
      nes_latch = 1'b0;
      cycles(PH);
   endtask

   task automatic host_clock();
      nes_clock = 1'b1;
      cycles(PH);
      nes_clock = 1'b0;
      cycles(PH);
   endtask

   // exp[i] is the nes_data level expected before the (i+1)-th clock pulse
   task automatic shift_check(input string tag, input logic [7:0] exp);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("%s[%0d]", tag, i), nes_data, exp[i]);
         host_clock();
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      buttons   = 8'h00;
      nes_latch = 1'b0;
      nes_clock = 1'b0;
      cycles(3);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_data", nes_data, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_fd", frame_done, 1'b0);

      // A, Select, Right
      buttons   = 8'b1000_0101;
      nes_latch = 1'b1;
      cycles(PH);
      chk("load_busy", busy, 1'b1);
      chk("load_data", nes_data, 1'b0);
      nes_latch = 1'b0;
      cycles(PH);
      chk("shift_busy", busy, 1'b1);
      shift_check("asr", 8'b0111_1010);
      chk("asr_fill", nes_data, 1'b0);
      chk("asr_busy", busy, 1'b0);
      chk("asr_fd", fd_count, 1);

      // all pressed, 10 clocks
      buttons = 8'hFF;
      fd0 = fd_count;
      host_latch();
      shift_check("all", 8'h00);
      host_clock();
      host_clock();
      chk("all_fill", nes_data, 1'b0);
      chk("all_busy", busy, 1'b0);
      chk("all_fd", fd_count - fd0, 1);

      // abort after 3 clocks, then relatch with Up only
      buttons = 8'h05;
      host_latch();
      chk("ab0", nes_data, 1'b0);
      host_clock();
      chk("ab1", nes_data, 1'b1);
      host_clock();
      chk("ab2", nes_data, 1'b0);
      host_clock();
      chk("ab3", nes_data, 1'b1);
      fd0 = fd_count;
      buttons = 8'h10;
      host_latch();
      chk("ab_fd", fd_count - fd0, 0);
      chk("ab_busy", busy, 1'b1);
      buttons = 8'hFF;
      shift_check("up", 8'b1110_1111);
      chk("up_fd", fd_count - fd0, 1);

      // latch and clock rising together during SHIFT
      buttons = 8'h01;
      host_latch();
      chk("sim_pre", nes_data, 1'b0);
      nes_latch = 1'b1;
      nes_clock = 1'b1;
      cycles(PH);
      chk("sim_data", nes_data, 1'b0);
      chk("sim_busy", busy, 1'b1);
      nes_latch = 1'b0;
      nes_clock = 1'b0;
      cycles(PH);
      chk("sim_hold", nes_data, 1'b0);
      host_clock();
      chk("sim_shift", nes_data, 1'b1);

      // reset mid-frame
      reset_n = 1'b0;
      #1;
      chk("mrst_data", nes_data, 1'b1);
      chk("mrst_busy", busy, 1'b0);
      cycles(2);
      reset_n = 1'b1;
      host_clock();
      chk("mrst_idle_data", nes_data, 1'b1);
      chk("mrst_idle_busy", busy, 1'b0);
      host_latch();
      chk("mrst_new", nes_data, 1'b0);

`ifdef NES_RESP_GLITCH_FILTER_EN
      nes_clock = 1'b1;
      cycles(2);
      nes_clock = 1'b0;
      cycles(PH);
      chk("glitch", nes_data, 1'b0);
      nes_clock = 1'b1;
      cycles(5);
      nes_clock = 1'b0;
      cycles(PH);
      chk("pulse5", nes_data, 1'b1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
